gpu_ram_port_arbiter: RTL
=========================

Name: gpu_ram_port_arbiter

Overview:
- Owns the 32-bit GPU-side port of the shared 4096x8 / 1024x32 dual-clock RAM.
- Arbitrates that port between three sources: the sprite/tile fetch requester (r0, read-only, real-time), a general read/write requester (r1), and a built-in fill engine that overwrites the whole RAM with a constant.
- Registers the memory command and tracks the RAM's 2-stage registered read pipeline, so each requester gets its own read-data valid strobe.

Parameters:
- FILL_VALUE, 32'h0000_0000, word written to every address by the fill engine.
- FILL_LAST, 10'd1023, last word address written by a fill; a fill covers 0..FILL_LAST.

Ports:
- clock  in  1  GPU clock; same clock as the RAM's clock_b.
- reset_n  in  1  Asynchronous, active-low reset.
- r0_req  in  1  Read request from the sprite/tile fetch requester.
- r0_addr  in  10  Word address for r0.
- r0_ack  out  1  Combinational; r0 request accepted this cycle.
- r0_rvalid  out  1  r0 read data valid.
- r0_rdata  out  32  r0 read data; equals mem_q.
- r1_req  in  1  Request from the general requester.
- r1_we  in  1  1 = write, 0 = read.
- r1_addr  in  10  Word address for r1.
- r1_wdata  in  32  Write data for r1.
- r1_ack  out  1  Combinational; r1 request accepted this cycle.
- r1_rvalid  out  1  r1 read data valid.
- r1_rdata  out  32  r1 read data; equals mem_q.
- fill_start  in  1  Single-cycle pulse; starts a fill.
- fill_busy  out  1  Fill in progress.
- fill_done  out  1  Single-cycle pulse after the final fill write is issued.
- mem_rden  out  1  To RAM rden_b.
- mem_wren  out  1  To RAM wren_b.
- mem_addr  out  10  To RAM address_b.
- mem_data  out  32  To RAM data_b.
- mem_q  in  32  From RAM q_b.

Behaviour:
- Reset values: all acks, rvalids, mem_rden, mem_wren, fill_busy and fill_done are 0; mem_addr = 0; mem_data = 0; fill address counter = 0; round-robin pointer = r1.
- Arbitration, evaluated every cycle:
  - r0 has fixed highest priority.
  - r1 and the fill engine share the remaining slots round-robin.
  - When both r1 and fill want a cycle, the pointer's owner wins, then the pointer moves to the other source.
  - When only one of them competes, it wins and the pointer is unchanged.
  - At most one grant per cycle. A requester holds req, address and data stable until it sees its ack.
- Command stage:
  - A granted request (ack high in cycle C0) is registered into mem_* at the end of C0.
  - mem_rden/mem_wren are high for exactly C1, one cycle per grant.
  - When nothing is granted, both are 0 in the following cycle. mem_addr and mem_data hold their last value.
- Read return:
  - A 2-stage tag pipeline (valid + requester id) follows the RAM's two registered read stages.
  - Read acked in C0 → rvalid for that requester high in C3, with mem_q valid that cycle.
  - Back-to-back reads give back-to-back rvalids in grant order; the two requester ids are never both valid in the same cycle.
  - Writes produce no rvalid.
- Fill FSM:
  - States: IDLE, RUN, DONE.
  - IDLE → RUN on fill_start: clear the counter, set fill_busy.
  - In RUN the engine requests continuously. Each grant issues a write of FILL_VALUE to the counter address, then increments the counter.
  - When the grant at address FILL_LAST occurs, go to DONE.
  - DONE lasts 1 cycle: fill_done = 1, fill_busy = 0, then back to IDLE.
  - fill_start in RUN or DONE is ignored.
  - Counter width is 10 bits and never wraps within a fill, because the FSM stops at FILL_LAST.
- Hazards:
  - Write granted in C0 followed by a read of the same address granted in C1: the read returns the new data, since the RAM commits the write before the read samples.
  - No further forwarding is required.
- Starvation:
  - Continuous r0 traffic starves r1 and fill; this is by design.
  - r1 and fill each get at least every second free slot.
- Asynchronous reset mid-operation aborts any fill and drops all in-flight rvalid tags. RAM contents are not touched.

Test Plan:
- After reset, no requests → all outputs 0 and fill_busy = 0. r0 read of addr 10'h005, with the RAM preloaded 32'hDEADBEEF at that word → r0_ack in C0, mem_rden = 1 with mem_addr = 5 in C1, r0_rvalid = 1 with r0_rdata = 32'hDEADBEEF in C3.
- r1 write of 32'h12345678 to addr 7 in C0, then r1 read of addr 7 in C1 → r1_rvalid in C4 with data 32'h12345678.
- r0 and r1 both requesting for 4 cycles → r0_ack every cycle, r1_ack never. Drop r0 → r1_ack the next cycle.
- fill_start pulse with r1 idle → 1024 consecutive mem_wren cycles at addresses 0..1023 with data FILL_VALUE, then a single fill_done pulse. fill_busy is high from the cycle after start through the last write.
- Fill running while r1 requests continuously (reads) → grants alternate fill/r1. r1 read addresses return the correct data, with r1_rvalid exactly 3 cycles after each r1_ack.
- Assert reset_n low at fill address 300 → fill_busy drops immediately and no further writes occur. A new fill_start after release restarts at address 0.

Source files
------------

// File: rtl/gpu_ram_port_arbiter.sv
// GPU-side port arbiter for the shared 1024x32 RAM: r0 (fixed priority), r1 and a fill engine
// share one registered command port; a tag pipeline routes read returns back to r0 or r1.
module gpu_ram_port_arbiter #(
    parameter logic [31:0] FILL_VALUE = 32'h0000_0000,
    parameter logic [9:0]  FILL_LAST  = 10'd1023
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        r0_req,
    input  logic [9:0]  r0_addr,
    output logic        r0_ack,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [9:0]  r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    input  logic        fill_start,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        mem_rden,
    output logic        mem_wren,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_q
);
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DONE} fill_state_e;
    typedef enum logic {SRC_R1, SRC_FILL} rr_src_e;
    typedef struct packed {
        logic valid;
        logic id;     // 0 = r0, 1 = r1
    } rd_tag_t;

    fill_state_e   fill_state_q, fill_state_d;
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    logic          fill_busy_q, fill_busy_d;
    logic          fill_done_q, fill_done_d;
    rr_src_e       rr_q, rr_d;

    logic          fill_req;
    logic          r0_grant, r1_grant, fill_grant;

    logic          mem_rden_q, mem_rden_d;
    logic          mem_wren_q, mem_wren_d;
    logic          mem_id_q, mem_id_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    rd_tag_t       tag1_q;
    logic          r0_rvalid_q, r1_rvalid_q;

    // r0 always wins; r1 and fill alternate only when both compete
    always_comb begin
        fill_req   = (fill_state_q == FILL_RUN);
        r0_grant   = r0_req;
        r1_grant   = 1'b0;
        fill_grant = 1'b0;
        rr_d       = rr_q;
        if (!r0_req) begin
            if (r1_req && fill_req) begin
                if (rr_q == SRC_R1) begin
                    r1_grant = 1'b1;
                    rr_d     = SRC_FILL;
                end else begin
                    fill_grant = 1'b1;
                    rr_d       = SRC_R1;
                end
            end else begin
                r1_grant   = r1_req;
                fill_grant = fill_req;
            end
        end
    end

    // Fill engine next state
    always_comb begin
        fill_state_d = fill_state_q;
        fill_cnt_d   = fill_cnt_q;
        fill_busy_d  = fill_busy_q;
        fill_done_d  = 1'b0;
        unique case (fill_state_q)
            FILL_IDLE: begin
                if (fill_start) begin
                    fill_state_d = FILL_RUN;
                    fill_cnt_d   = '0;
                    fill_busy_d  = 1'b1;
                end
            end
            FILL_RUN: begin
                if (fill_grant) begin
                    if (fill_cnt_q == FILL_LAST) begin
                        fill_state_d = FILL_DONE;
                        fill_busy_d  = 1'b0;
                        fill_done_d  = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt_q + AW'(1);
                    end
                end
            end
            FILL_DONE: fill_state_d = FILL_IDLE;
            default: begin
                fill_state_d = FILL_IDLE;
                fill_busy_d  = 1'b0;
            end
        endcase
    end

    // Command for the RAM; address and data hold when nothing is granted
    always_comb begin
        mem_rden_d = r0_grant | (r1_grant & ~r1_we);
        mem_wren_d = (r1_grant & r1_we) | fill_grant;
        mem_id_d   = r1_grant;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (r0_grant) begin
            mem_addr_d = r0_addr;
        end else if (r1_grant) begin
            mem_addr_d = r1_addr;
            if (r1_we) begin
                mem_data_d = r1_wdata;
            end
        end else if (fill_grant) begin
            mem_addr_d = fill_cnt_q;
            mem_data_d = FILL_VALUE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_state_q <= FILL_IDLE;
            fill_cnt_q   <= '0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            rr_q         <= SRC_R1;
            mem_rden_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_id_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            tag1_q       <= '0;
            r0_rvalid_q  <= 1'b0;
            r1_rvalid_q  <= 1'b0;
        end else begin
            fill_state_q <= fill_state_d;
            fill_cnt_q   <= fill_cnt_d;
            fill_busy_q  <= fill_busy_d;
            fill_done_q  <= fill_done_d;
            rr_q         <= rr_d;
            mem_rden_q   <= mem_rden_d;
            mem_wren_q   <= mem_wren_d;
            mem_id_q     <= mem_id_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            // Two tag stages track the RAM's address and output registers
            tag1_q.valid <= mem_rden_q;
            tag1_q.id    <= mem_id_q;
            r0_rvalid_q  <= tag1_q.valid & ~tag1_q.id;
            r1_rvalid_q  <= tag1_q.valid & tag1_q.id;
        end
    end

    assign r0_ack    = r0_grant;
    assign r1_ack    = r1_grant;
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = mem_q;
    assign r1_rdata  = mem_q;
    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;
    assign mem_rden  = mem_rden_q;
    assign mem_wren  = mem_wren_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;

endmodule
